tri_raster_ctrl: RTL and testbench

- Sequencing controller that rasterises one triangle at a time.
- Accepts three vertices over a valid/ready handshake and scans their bounding box in raster order.
- Time-multiplexes a single orientation (sign) unit over the three edge tests of each pixel.
- Streams the pixels found strictly inside the triangle to a downstream consumer; sits between the geometry source and the pixel writer.

---
 rtl/tri_raster_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_tri_raster_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_raster_ctrl.sv
// Triangle rasteriser controller: scans the vertex bounding box in raster order and
// streams strictly-inside pixels. Define TRI_STATS_EN to add tested_cnt/inside_cnt.
module tri_raster_ctrl #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [W-1:0] p1x,
    input  logic [W-1:0] p1y,
    input  logic [W-1:0] p2x,
    input  logic [W-1:0] p2y,
    input  logic [W-1:0] p3x,
    input  logic [W-1:0] p3y,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [W-1:0] pix_x,
    output logic [W-1:0] pix_y,
    output logic         busy,
`ifdef TRI_STATS_EN
    output logic [2*W:0] tested_cnt,
    output logic [2*W:0] inside_cnt,
`endif
    output logic         done
);

    localparam int MW = 2 * W + 2;

    typedef enum logic [2:0] {
        st_idle,
        st_bbox,
        st_eval,
        st_emit,
        st_step,
        st_done
    } state_t;

    state_t state;

    logic [W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [W-1:0] xmin, xmax, ymin, ymax;
    logic [W-1:0] cx, cy;
    logic [1:0]   e;
    logic         s0, s1;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic [W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;

    assign bb_xmin = min3(v1x, v2x, v3x);
    assign bb_xmax = max3(v1x, v2x, v3x);
    assign bb_ymin = min3(v1y, v2y, v3y);
    assign bb_ymax = max3(v1y, v2y, v3y);

    // Shared orientation unit: e selects the edge (V1,V2), (V2,V3) or (V3,V1).
    logic [W-1:0] ax, ay, bx, by;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ax = v1x;
        ay = v1y;
        bx = v2x;
        by = v2y;
        case (e)
            2'd1: begin
                ax = v2x;
                ay = v2y;
                bx = v3x;
                by = v3y;
            end
            2'd2: begin
                ax = v3x;
                ay = v3y;
                bx = v1x;
                by = v1y;
            end
            default: ;
        endcase
    end

    logic signed [W:0]    c1, c2, c3, c4;
    logic signed [MW-1:0] m1, m2;
    logic                 s_cur;

    assign c1    = {1'b0, cx} - {1'b0, bx};
    assign c2    = {1'b0, ay} - {1'b0, by};
    assign c3    = {1'b0, ax} - {1'b0, bx};
    assign c4    = {1'b0, cy} - {1'b0, by};
    assign m1    = MW'(c1) * MW'(c2);
    assign m2    = MW'(c3) * MW'(c4);
    assign s_cur = (m1 < m2);

    assign tri_ready = (state == st_idle);

    // NOTE: sequential state uses <= so every branch sees the pre-edge register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= st_idle;
            v1x        <= '0;
            v1y        <= '0;
            v2x        <= '0;
            v2y        <= '0;
            v3x        <= '0;
            v3y        <= '0;
            xmin       <= '0;
            xmax       <= '0;
            ymin       <= '0;
            ymax       <= '0;
            cx         <= '0;
            cy         <= '0;
            e          <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef TRI_STATS_EN
            tested_cnt <= '0;
            inside_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (tri_valid) begin
                        v1x   <= p1x;
                        v1y   <= p1y;
                        v2x   <= p2x;
                        v2y   <= p2y;
                        v3x   <= p3x;
                        v3y   <= p3y;
                        busy  <= 1'b1;
                        state <= st_bbox;
`ifdef TRI_STATS_EN
                        tested_cnt <= '0;
                        inside_cnt <= '0;
`endif
                    end
                end
                st_bbox: begin
                    xmin  <= bb_xmin;
                    xmax  <= bb_xmax;
                    ymin  <= bb_ymin;
                    ymax  <= bb_ymax;
                    cx    <= bb_xmin;
                    cy    <= bb_ymin;
                    e     <= 2'd0;
                    state <= st_eval;
                end
                st_eval: begin
                    case (e)
                        2'd0: begin
                            s0 <= s_cur;
                            e  <= 2'd1;
                        end
                        2'd1: begin
                            s1 <= s_cur;
                            e  <= 2'd2;
                        end
                        default: begin
                            e <= 2'd0;
                            // Third edge is used straight from the unit, never stored.
                            if (s0 == s1 && s1 == s_cur) begin
                                pix_valid <= 1'b1;
                                pix_x     <= cx;
                                pix_y     <= cy;
                                state     <= st_emit;
                            end else begin
                                state <= st_step;
                            end
                        end
                    endcase
                end
                st_emit: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        state     <= st_step;
`ifdef TRI_STATS_EN
                        inside_cnt <= inside_cnt + (2*W+1)'(1);
`endif
                    end
                end
                st_step: begin
`ifdef TRI_STATS_EN
                    tested_cnt <= tested_cnt + (2*W+1)'(1);
`endif
                    e <= 2'd0;
                    if (cx == xmax && cy == ymax) begin
                        done  <= 1'b1;
                        state <= st_done;
                    end else if (cx == xmax) begin
                        cx    <= xmin;
                        cy    <= cy + W'(1);
                        state <= st_eval;
                    end else begin
                        cx    <= cx + W'(1);
                        state <= st_eval;
                    end
                end
                st_done: begin
                    busy  <= 1'b0;
                    state <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Directed bench for tri_raster_ctrl: fixed triangles with hand-derived pixel lists and
// cycle counts. Stats checks run only when TRI_STATS_EN is defined.
module tb_tri_raster_ctrl;

    localparam int W = 11;

    logic         clk, rst_n, tri_valid, tri_ready;
    logic [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic         pix_valid, pix_ready, busy, done;
    logic [W-1:0] pix_x, pix_y;
`ifdef TRI_STATS_EN
    logic [2*W:0] tested_cnt, inside_cnt;
`endif

    int n_vec, n_err;
    int px_q[$], py_q[$];
    int stab_err;
    logic busy_at_start, done_after, busy_after, ready_after;

    tri_raster_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .p1x       (p1x),
        .p1y       (p1y),
        .p2x       (p2x),
        .p2y       (p2y),
        .p3x       (p3x),
        .p3y       (p3y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .busy      (busy),
`ifdef TRI_STATS_EN
        .tested_cnt(tested_cnt),
        .inside_cnt(inside_cnt),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one triangle from a #1-after-edge point. cyc is the index of the clock edge,
    // counted from the accepting edge, that captures done high. stall holds pix_ready low
    // for that many extra cycles of each EMIT; poke_at re-pulses tri_valid mid-run.
    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int qx, input int qy, input int stall, input int poke_at,
                           output int cyc);
        int held;
        bit got;
        int hx, hy;
        px_q.delete();
        py_q.delete();
        stab_err  = 0;
        held      = 0;
        got       = 0;
        hx        = 0;
        hy        = 0;
        pix_ready = (stall == 0);
        p1x = W'(ax); p1y = W'(ay);
        p2x = W'(bx); p2y = W'(by);
        p3x = W'(qx); p3y = W'(qy);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid     = 1'b0;
        busy_at_start = busy;
        cyc           = 0;
        while (!got && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (tri_valid) tri_valid = 1'b0;
            if (cyc == poke_at) begin
                tri_valid = 1'b1;
                p1x = W'(100); p1y = W'(7);
                p2x = W'(3);   p2y = W'(90);
                p3x = W'(60);  p3y = W'(60);
            end
            if (done) begin
                got = 1;
            end else if (pix_valid) begin
                if (held == 0) begin
                    hx = int'(pix_x);
                    hy = int'(pix_y);
                    px_q.push_back(hx);
                    py_q.push_back(hy);
                end else if (int'(pix_x) != hx || int'(pix_y) != hy) begin
                    stab_err++;
                end
                held++;
                if (held > stall) pix_ready = 1'b1;
            end else begin
                held      = 0;
                pix_ready = (stall == 0);
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: done not seen after %0d cycles, want done", cyc);
        end
        cyc       = cyc + 1;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        done_after  = done;
        busy_after  = busy;
        ready_after = tri_ready;
    endtask

    task automatic test_reset;
        n_vec++;
        if (tri_ready !== 1'b1) begin n_err++; $display("FAIL reset_tri_ready: got %b want 1", tri_ready); end
        n_vec++;
        if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++;
        if (pix_x !== '0 || pix_y !== '0) begin
            n_err++; $display("FAIL reset_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
`ifdef TRI_STATS_EN
        n_vec++;
        if (tested_cnt !== '0 || inside_cnt !== '0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", tested_cnt, inside_cnt);
        end
`endif
    endtask

    // (0,0),(0,4),(4,0): inside where x>0, y>0, x+y<4.
    task automatic test_basic(input string tag);
        int cyc;
        int ex[3] = '{1, 2, 1};
        int ey[3] = '{1, 1, 2};
        run_tri(0, 0, 0, 4, 4, 0, 0, -1, cyc);
        n_vec++;
        if (busy_at_start !== 1'b1) begin n_err++; $display("FAIL %s_busy_start: got %b want 1", tag, busy_at_start); end
        n_vec++;
        if (cyc != 105) begin n_err++; $display("FAIL %s_cycles: got %0d want 105", tag, cyc); end
        n_vec++;
        if (px_q.size() != 3) begin n_err++; $display("FAIL %s_count: got %0d want 3", tag, px_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= px_q.size() || px_q[i] != ex[i] || py_q[i] != ey[i]) begin
                n_err++;
                $display("FAIL %s_pix%0d: got (%0d,%0d) want (%0d,%0d)", tag, i,
                         (i < px_q.size()) ? px_q[i] : -1, (i < py_q.size()) ? py_q[i] : -1, ex[i], ey[i]);
            end
        end
        n_vec++;
        if (done_after !== 1'b0 || busy_after !== 1'b0 || ready_after !== 1'b1) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%b busy=%b ready=%b want 0 0 1", tag,
                     done_after, busy_after, ready_after);
        end
    endtask

    task automatic test_stall;
        int cyc;
        int ex[3] = '{1, 2, 1};
        int ey[3] = '{1, 1, 2};
        run_tri(0, 0, 0, 4, 4, 0, 10, -1, cyc);
        n_vec++;
        if (cyc != 135) begin n_err++; $display("FAIL stall_cycles: got %0d want 135", cyc); end
        n_vec++;
        if (stab_err != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        n_vec++;
        if (px_q.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", px_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= px_q.size() || px_q[i] != ex[i] || py_q[i] != ey[i]) begin
                n_err++;
                $display("FAIL stall_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                         (i < px_q.size()) ? px_q[i] : -1, (i < py_q.size()) ? py_q[i] : -1, ex[i], ey[i]);
            end
        end
    endtask

    // Single-point box: BBOX + 3 EVAL + EMIT + STEP, done captured at edge 7.
    task automatic test_degenerate;
        int cyc;
        run_tri(5, 5, 5, 5, 5, 5, 0, -1, cyc);
        n_vec++;
        if (cyc != 7) begin n_err++; $display("FAIL degen_cycles: got %0d want 7", cyc); end
        n_vec++;
        if (px_q.size() != 1 || px_q[0] != 5 || py_q[0] != 5) begin
            n_err++;
            $display("FAIL degen_pix: got %0d pixels first (%0d,%0d) want 1 pixel (5,5)", px_q.size(),
                     (px_q.size() > 0) ? px_q[0] : -1, (py_q.size() > 0) ? py_q[0] : -1);
        end
    endtask

    // Box 2040..2047 squared (64 pixels). Interior: x<2047, y<2047, x+y>4087 -> 15 pixels;
    // (2046,2046) sits well clear of the hypotenuse x+y=4087 and is emitted last.
    task automatic test_max_corner;
        int cyc;
        int bad;
        run_tri(2047, 2047, 2047, 2040, 2040, 2047, 0, -1, cyc);
        n_vec++;
        if (cyc != 273) begin n_err++; $display("FAIL max_cycles: got %0d want 273", cyc); end
        n_vec++;
        if (px_q.size() != 15) begin n_err++; $display("FAIL max_count: got %0d want 15", px_q.size()); end
        n_vec++;
        if (px_q.size() == 0 || px_q[0] != 2046 || py_q[0] != 2042) begin
            n_err++;
            $display("FAIL max_first: got (%0d,%0d) want (2046,2042)",
                     (px_q.size() > 0) ? px_q[0] : -1, (py_q.size() > 0) ? py_q[0] : -1);
        end
        n_vec++;
        if (px_q.size() == 0 || px_q[px_q.size()-1] != 2046 || py_q[py_q.size()-1] != 2046) begin
            n_err++;
            $display("FAIL max_last: got (%0d,%0d) want (2046,2046)",
                     (px_q.size() > 0) ? px_q[px_q.size()-1] : -1, (py_q.size() > 0) ? py_q[py_q.size()-1] : -1);
        end
        bad = 0;
        foreach (px_q[i]) begin
            if (!(px_q[i] < 2047 && py_q[i] < 2047 && px_q[i] + py_q[i] > 4087)) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL max_interior: got %0d off-interior pixels want 0", bad); end
    endtask

    task automatic test_reset_mid;
        bit done_seen;
        pix_ready = 1'b1;
        p1x = W'(0); p1y = W'(0);
        p2x = W'(0); p2y = W'(4);
        p3x = W'(4); p3y = W'(0);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0 || tri_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_outputs: got busy=%b pix_valid=%b done=%b ready=%b want 0 0 0 1",
                     busy, pix_valid, done, tri_ready);
        end
        n_vec++;
        if (pix_x !== '0 || pix_y !== '0) begin
            n_err++; $display("FAIL rstmid_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) done_seen = 1;
        n_vec++;
        if (done_seen) begin n_err++; $display("FAIL rstmid_no_done: got done pulse want none"); end
        n_vec++;
        if (tri_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", tri_ready); end
        test_basic("rerun");
    endtask

`ifdef TRI_STATS_EN
    task automatic test_stats;
        int cyc;
        run_tri(0, 0, 0, 4, 4, 0, 0, 50, cyc);
        n_vec++;
        if (cyc != 105 || px_q.size() != 3) begin
            n_err++; $display("FAIL stats_run: got cyc=%0d pixels=%0d want 105 3", cyc, px_q.size());
        end
        n_vec++;
        if (tested_cnt !== 23'd25) begin n_err++; $display("FAIL stats_tested: got %0d want 25", tested_cnt); end
        n_vec++;
        if (inside_cnt !== 23'd3) begin n_err++; $display("FAIL stats_inside: got %0d want 3", inside_cnt); end
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (tested_cnt !== 23'd25 || inside_cnt !== 23'd3) begin
            n_err++; $display("FAIL stats_hold: got %0d/%0d want 25/3", tested_cnt, inside_cnt);
        end
        run_tri(5, 5, 5, 5, 5, 5, 0, -1, cyc);
        n_vec++;
        if (tested_cnt !== 23'd1 || inside_cnt !== 23'd1) begin
            n_err++; $display("FAIL stats_clear: got %0d/%0d want 1/1", tested_cnt, inside_cnt);
        end
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        #12;
        test_reset;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic("basic");
        test_stall;
        test_degenerate;
        test_max_corner;
        test_reset_mid;
`ifdef TRI_STATS_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
